// File: rtl/mano_pkg.sv
// rtl/mano_pkg.sv - shared constants and types for the Mano control-unit datapath blocks
package mano_pkg;

    localparam int MANO_BITS       = 16;
    localparam int MANO_REQUESTERS = 4;

    typedef logic [$clog2(MANO_REQUESTERS)-1:0] req_idx_t;

endpackage

// File: rtl/RippleCarryIncrementer.sv
// rtl/RippleCarryIncrementer.sv - combinational ripple-carry a+1 with carry-out
module RippleCarryIncrementer #(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] i_a,
    output logic [BITS-1:0] o_sum,
    output logic            o_cout
);

    logic [BITS:0] w_carry;

    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < BITS; g++) begin : g_bit
        assign o_sum[g]     = i_a[g] ^ w_carry[g];
        assign w_carry[g+1] = i_a[g] & w_carry[g];
    end

    assign o_cout = w_carry[BITS];

endmodule

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin pick starting at a pointer
module rr_priority_select #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_req[j] && (j >= int'(i_ptr))) begin
                o_any = 1'b1;
                o_idx = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_req[j]) begin
                o_any = 1'b1;
                o_idx = IW'(j);
            end
        end
        o_onehot = o_any ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/incrementer_arbiter.sv
// rtl/incrementer_arbiter.sv - round-robin shared incrementer with registered grant/result
module incrementer_arbiter
    import mano_pkg::*;
#(
    parameter int BITS       = MANO_BITS,
    parameter int REQUESTERS = MANO_REQUESTERS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic [REQUESTERS-1:0]      req,
    input  logic [REQUESTERS*BITS-1:0] operand,
    output logic [REQUESTERS-1:0]      grant,
    output logic [BITS-1:0]            result,
    output logic                       c_out,
    output logic                       valid
);

    localparam int IW = $clog2(REQUESTERS);

    logic [REQUESTERS-1:0] r_grant;
    logic [BITS-1:0]       r_result;
    logic                  r_c_out;
    logic                  r_valid;
    logic [IW-1:0]         r_ptr;

    logic [REQUESTERS-1:0] w_eligible;
    logic [REQUESTERS-1:0] w_win_oh;
    logic [IW-1:0]         w_win_idx;
    logic                  w_any;
    logic [BITS-1:0]       w_operand;
    logic [BITS-1:0]       w_sum;
    logic                  w_cout;
    logic [IW-1:0]         w_ptr_nxt;
    logic                  w_take;

    // A client is masked while its own grant is showing, so a late-dropped req is not re-served.
    assign w_eligible = req & ~r_grant;

    rr_priority_select #(
        .N  (REQUESTERS),
        .IW (IW)
    ) u_select (
        .i_req    (w_eligible),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_any    (w_any)
    );

    always_comb begin
        w_operand = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (w_win_idx == IW'(i)) begin
                w_operand = operand[i*BITS +: BITS];
            end
        end
    end

    RippleCarryIncrementer #(
        .BITS (BITS)
    ) u_inc (
        .i_a    (w_operand),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_ptr_nxt = (w_win_idx == IW'(REQUESTERS-1)) ? '0 : w_win_idx + IW'(1);
    assign w_take    = w_any && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_result <= '0;
            r_c_out  <= 1'b0;
            r_valid  <= 1'b0;
            r_ptr    <= '0;
        end else if (w_take) begin
            r_grant  <= w_win_oh;
            r_result <= w_sum;
            r_c_out  <= w_cout;
            r_valid  <= 1'b1;
            r_ptr    <= w_ptr_nxt;
        end else begin
            r_grant  <= '0;
            r_valid  <= 1'b0;
        end
    end

    assign grant  = r_grant;
    assign result = r_result;
    assign c_out  = r_c_out;
    assign valid  = r_valid;

endmodule

// File: tb/tb_incrementer_arbiter.sv
// tb/tb_incrementer_arbiter.sv - randomized and directed bench against a behavioural arbiter model
module tb_incrementer_arbiter;

    localparam int BITS = 16;
    localparam int N    = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                stall = 1'b0;
    logic [N-1:0]        req = '0;
    logic [N*BITS-1:0]   operand = '0;
    logic [N-1:0]        grant;
    logic [BITS-1:0]     result;
    logic                c_out;
    logic                valid;

    incrementer_arbiter #(
        .BITS       (BITS),
        .REQUESTERS (N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .req     (req),
        .operand (operand),
        .grant   (grant),
        .result  (result),
        .c_out   (c_out),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BITS-1:0] op [N];

    int              m_ptr;
    int              m_gidx;
    logic [BITS-1:0] m_res;
    logic            m_c;
    logic [N-1:0]    e_grant;
    logic            e_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) operand[i*BITS +: BITS] = op[i];
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_gidx  = -1;
        m_res   = '0;
        m_c     = 1'b0;
        e_grant = '0;
        e_valid = 1'b0;
    endtask

    // Round-robin scan from the pointer, skipping whichever client is currently shown granted.
    task automatic model_edge();
        int w;
        logic [BITS:0] s;
        w = -1;
        if (!stall) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (w < 0 && req[i] && i != m_gidx) w = i;
            end
        end
        if (w >= 0) begin
            s       = {1'b0, op[w]} + 1;
            m_res   = s[BITS-1:0];
            m_c     = s[BITS];
            m_ptr   = (w + 1) % N;
            e_grant = N'(1) << w;
            e_valid = 1'b1;
        end else begin
            e_grant = '0;
            e_valid = 1'b0;
        end
        m_gidx = w;
    endtask

    task automatic cyc(input string tag);
        drive_ops();
        model_edge();
        @(posedge clk);
        #1;
        check({tag, "_grant"}, 32'(grant), 32'(e_grant));
        check({tag, "_valid"}, 32'(valid), 32'(e_valid));
        check({tag, "_result"}, 32'(result), 32'(m_res));
        check({tag, "_cout"}, 32'(c_out), 32'(m_c));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_cout"}, 32'(c_out), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check_cleared(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt3;
        for (int i = 0; i < N; i++) op[i] = '0;
        model_reset();
        #3;
        do_reset("rst0");

        // Single request, then drop: result holds.
        op[0] = 16'h1265;
        req   = 4'b0001;
        cyc("single");
        check("single_res_k", 32'(result), 32'h1266);
        req = '0;
        cyc("single_drop");
        check("single_hold_k", 32'(result), 32'h1266);

        // All-ones and zero operands.
        op[2] = 16'hFFFF;
        req   = 4'b0100;
        cyc("wrap_ff");
        check("wrap_ff_k", 32'({c_out, result}), 32'h10000);
        req = '0;
        cyc("wrap_gap");
        op[2] = 16'h0000;
        req   = 4'b0100;
        cyc("wrap_00");
        check("wrap_00_k", 32'({c_out, result}), 32'h00001);
        req = '0;
        cyc("wrap_idle");

        // All request from reset, each dropping on its grant.
        do_reset("rst1");
        for (int i = 0; i < N; i++) op[i] = BITS'(16'h1000 * (i + 1) + i);
        req = '1;
        for (int k = 0; k < N; k++) begin
            cyc("allreq");
            check("allreq_order", 32'(grant), 32'(N'(1) << k));
            req = req & ~e_grant;
        end
        cyc("allreq_end");

        // Clients 0 and 3 held high: client 3 must keep getting served.
        req  = 4'b1001;
        cnt3 = 0;
        for (int k = 0; k < 8; k++) begin
            cyc("fair");
            if (grant[3]) cnt3++;
        end
        check("fair_c3_served", 32'(cnt3 >= 3), 32'd1);
        req = '0;
        cyc("fair_end");

        // Stall freezes arbitration, then resumes at the pointer.
        req   = '1;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) cyc("stall");
        stall = 1'b0;
        cyc("stall_rel");

        // Asynchronous reset during a grant cycle.
        req = '1;
        cyc("pre_rst");
        check("pre_rst_valid_k", 32'(valid), 32'd1);
        do_reset("rst_mid");
        req = '1;
        cyc("post_rst");
        check("post_rst_first_k", 32'(grant), 32'b0001);
        req = '0;
        cyc("post_rst_idle");

        // Randomized clients obeying the handshake, with random stalls.
        for (int t = 0; t < 2000; t++) begin
            stall = ($urandom_range(0, 7) == 0);
            cyc("rand");
            for (int i = 0; i < N; i++) begin
                if (e_grant[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req[i] = 1'b0;
                        op[i]  = BITS'($urandom);
                    end
                end else if (!req[i]) begin
                    case ($urandom_range(0, 3))
                        0: op[i] = '1;
                        1: op[i] = '0;
                        default: op[i] = BITS'($urandom);
                    endcase
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/incrementer_arbiter.md
Name: incrementer_arbiter

Overview:
- Shares one BITS-wide ripple-carry incrementer datapath among REQUESTERS clients, for example PC, AR, SC and DR increment paths in the Mano control unit.
- Round-robin arbitration, at most one grant per clock.
- Result, carry-out and one-hot grant are registered, so they appear in the cycle after the winning request is sampled.
- Sits between the control-sequence logic and the register file; replaces per-register incrementers.

Parameters:
- BITS, 16, operand/result width.
- REQUESTERS, 4, number of clients (2..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  freezes arbitration: no new grant while high.
- req  in  REQUESTERS  per-client increment request, level.
- operand  in  REQUESTERS*BITS  flattened operands; client i occupies [i*BITS +: BITS].
- grant  out  REQUESTERS  one-hot, registered; pulse marks completion for that client.
- result  out  BITS  registered operand+1 (mod 2^BITS) of granted client.
- c_out  out  1  registered carry-out; 1 only when the granted operand was all ones.
- valid  out  1  registered; high iff grant is non-zero.

Behaviour:
- Reset: asynchronous on rst_n low. grant=0, valid=0, result=0, c_out=0, priority pointer=0. All outputs clear immediately, including mid-transaction; any in-flight grant is dropped.
- Release is synchronous to the first clk edge after rst_n rises.
- Cycle N (sampling), when stall=0 and a request is eligible:
  - Winner = first eligible i scanning ptr, ptr+1, ..., wrapping mod REQUESTERS.
  - Eligible means req[i]=1 and grant[i]=0 in cycle N.
- Cycle N+1 (output): grant=onehot(winner), valid=1, result=operand_N[winner]+1, c_out=carry. Pointer becomes (winner+1) mod REQUESTERS.
- Cycle N with no eligible request, or stall=1: next grant=0, valid=0; result/c_out hold their last values; pointer holds.
- Handshake:
  - Client holds req and a stable operand until it sees its grant bit.
  - Client drops req in the grant cycle.
  - A req still high during its own grant cycle is ignored (masked), which prevents double service.
  - Back-to-back service of the same client therefore needs one idle cycle. Other clients can be granted in consecutive cycles.
- Latency: 1 cycle from sampled request to grant/result. Throughput: 1 increment per cycle.
- Wrap-around: operand all-ones gives result 0, c_out 1. Operand 0 gives result 1, c_out 0.
- Pointer wrap: winner REQUESTERS-1 moves ptr to 0.
- Fairness: any continuously requesting client is granted within REQUESTERS grant cycles.
- stall asserted in the same cycle as a grant output: that grant still completes; the next cycle produces no grant.
- Operand changes while not granted have no effect. Only the value sampled at the winning edge is used.

Decomposition:
- Shared package mano_pkg: BITS default constant, REQUESTERS default constant, typedef req_idx_t (width $clog2(REQUESTERS)).
- Datapath: one instance of the existing RippleCarryIncrementer (BITS) on the muxed operand. Its combinational outputs are registered here.
- Sub-module rr_priority_select: inputs req mask and pointer; outputs one-hot winner and index. Purely combinational and reusable by other arbiters.

Test Plan:
- Single request: req=4'b0001, operand0=16'h1265 -> next cycle grant=0001, valid=1, result=16'h1266, c_out=0. Drop req -> following cycle valid=0, result holds 16'h1266.
- Wrap: req=4'b0100, operand2=16'hFFFF -> grant=0100, result=16'h0000, c_out=1. Operand2=16'h0000 -> result=16'h0001, c_out=0.
- All request from reset, each client dropping req on its grant (ptr=0): grants 0001, 0010, 0100, 1000 on consecutive cycles, results = each operand+1.
- Fairness: clients 0 and 3 held high, each re-raising req after its grant: grants alternate 0001, 1000 (with a masked cycle) and never starve client 3.
- Stall: all req high, stall=1 for 3 cycles -> valid=0, pointer unchanged. Release -> grant resumes at the pointer client.
- Reset mid-operation: rst_n low asynchronously in a grant cycle -> grant=0, valid=0, result=0, c_out=0 before the next edge. After release, the first grant goes to client 0.
